adder_operand_sequencer: RTL and testbench

- Sequential front/back-end for the 4-bit carry-lookahead adder stage.
- Captures operands A, B and carry-in from four data switches, a carry switch and one pushbutton.
- Drives the adder's packed 9-bit input vector from registers, then captures its 5-bit result for display.
- Optional accumulate mode chains the previous sum back in as the next A operand.

---
 rtl/adder_operand_sequencer.sv | 118 +++++++++++
 tb/tb_adder_operand_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_operand_sequencer.sv
// Operand capture and result display sequencer for the 4-bit carry-lookahead adder stage.
// A debounced pushbutton steps through LOAD_A -> LOAD_B -> ADD -> SHOW; accumulate mode feeds the sum back as A.
module adder_operand_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data_sw,
  input  logic       cin_sw,
  input  logic       btn_next,
  input  logic       acc_mode,
  output logic [8:0] adder_in,
  input  logic [4:0] adder_out,
  output logic [4:0] led,
  output logic       result_valid,
  output logic [3:0] state_led,
  output logic [3:0] carry_count
);

  // One-hot encoding so the state register doubles as the state_led debug output.
  typedef enum logic [3:0] {
    S_LOAD_A = 4'b0001,
    S_LOAD_B = 4'b0010,
    S_ADD    = 4'b0100,
    S_SHOW   = 4'b1000
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  logic             sync1;
  logic             sync2;
  logic             db_level;
  logic [CNT_W-1:0] db_cnt;
  logic             press;
  logic [3:0]       a_reg;
  logic [3:0]       b_reg;
  logic             cin_reg;

  // press is a registered one-cycle pulse emitted on the edge where the debounced level rises.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      db_level <= 1'b0;
      db_cnt   <= '0;
      press    <= 1'b0;
    end else begin
      sync1 <= btn_next;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= sync2;
        db_cnt   <= '0;
        press    <= sync2;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_LOAD_A;
      a_reg        <= 4'h0;
      b_reg        <= 4'h0;
      cin_reg      <= 1'b0;
      led          <= 5'h00;
      result_valid <= 1'b0;
      carry_count  <= 4'h0;
    end else begin
      case (state)
        S_LOAD_A: begin
          if (press) begin
            a_reg <= data_sw;
            state <= S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (press) begin
            b_reg   <= data_sw;
            cin_reg <= cin_sw;
            state   <= S_ADD;
          end
        end
        S_ADD: begin
          // A press landing here is dropped on purpose; the adder result is already settled.
          led          <= adder_out;
          result_valid <= 1'b1;
          if (adder_out[4] && (carry_count != 4'hF)) begin
            carry_count <= carry_count + 4'h1;
          end
          state <= S_SHOW;
        end
        S_SHOW: begin
          if (press) begin
            result_valid <= 1'b0;
            if (acc_mode) begin
              a_reg <= led[3:0];
              state <= S_LOAD_B;
            end else begin
              state <= S_LOAD_A;
            end
          end
        end
        default: state <= S_LOAD_A;
      endcase
    end
  end

  assign state_led = state;
  assign adder_in  = {b_reg[3], a_reg[3], b_reg[2], a_reg[2],
                      b_reg[1], a_reg[1], cin_reg, b_reg[0], a_reg[0]};

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Bench for adder_operand_sequencer: behavioural adder in the loop, random operand sequences,
// scoreboard of expected {carry_count, led} popped whenever result_valid rises.
module tb_adder_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] data_sw;
  logic       cin_sw;
  logic       btn_next;
  logic       acc_mode;
  logic [8:0] adder_in;
  logic [4:0] adder_out;
  logic [4:0] led;
  logic       result_valid;
  logic [3:0] state_led;
  logic [3:0] carry_count;

  int n_checks = 0;
  int n_fail   = 0;
  int state_changes = 0;

  logic [8:0] exp_q[$];

  // Reference model state
  int         m_phase;   // 0=LOAD_A 1=LOAD_B 3=SHOW
  logic [3:0] m_a, m_b;
  logic       m_cin;
  logic [4:0] m_led;
  logic [3:0] m_cc;

  adder_operand_sequencer #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .data_sw(data_sw), .cin_sw(cin_sw),
    .btn_next(btn_next), .acc_mode(acc_mode), .adder_in(adder_in),
    .adder_out(adder_out), .led(led), .result_valid(result_valid),
    .state_led(state_led), .carry_count(carry_count)
  );

  always #5 clk = ~clk;

  // External adder stage modelled arithmetically from the packed input vector.
  always_comb begin
    logic [3:0] aa, bb;
    aa = {adder_in[7], adder_in[5], adder_in[3], adder_in[0]};
    bb = {adder_in[8], adder_in[6], adder_in[4], adder_in[1]};
    adder_out = 5'(aa) + 5'(bb) + 5'(adder_in[2]);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] pack(input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [8:0] v;
    v[0] = a[0]; v[1] = b[0]; v[2] = c;
    v[3] = a[1]; v[4] = b[1]; v[5] = a[2];
    v[6] = b[2]; v[7] = a[3]; v[8] = b[3];
    return v;
  endfunction

  function automatic logic [3:0] phase_onehot(input int p);
    case (p)
      0:       return 4'b0001;
      1:       return 4'b0010;
      default: return 4'b1000;
    endcase
  endfunction

  // Monitor: pops on each rising result_valid, also counts state changes.
  logic       rv_q = 1'b0;
  logic [3:0] sl_q = 4'b0001;
  always @(negedge clk) begin
    if (rst_n && result_valid && !rv_q) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("scoreboard_cc_led", int'({carry_count, led}), int'(e));
      end
    end
    rv_q = result_valid;
    if (state_led != sl_q) state_changes++;
    sl_q = state_led;
  end

  task automatic check_all(input string tag);
    chk({tag, "_state_led"}, int'(state_led), int'(phase_onehot(m_phase)));
    chk({tag, "_adder_in"}, int'(adder_in), int'(pack(m_a, m_b, m_cin)));
    chk({tag, "_led"}, int'(led), int'(m_led));
    chk({tag, "_result_valid"}, int'(result_valid), (m_phase == 3) ? 1 : 0);
    chk({tag, "_carry_count"}, int'(carry_count), int'(m_cc));
  endtask

  task automatic model_press(input logic [3:0] d, input logic c, input logic acc);
    int s;
    case (m_phase)
      0: begin m_a = d; m_phase = 1; end
      1: begin
        m_b = d; m_cin = c;
        s = int'(m_a) + int'(m_b) + int'(c);
        m_led = 5'(s);
        if (s >= 16 && m_cc < 15) m_cc = m_cc + 1;
        exp_q.push_back({m_cc, m_led});
        m_phase = 3;
      end
      default: begin
        if (acc) begin m_a = m_led[3:0]; m_phase = 1; end
        else m_phase = 0;
      end
    endcase
  endtask

  task automatic do_press(input logic [3:0] d, input logic c, input logic acc);
    data_sw = d; cin_sw = c; acc_mode = acc;
    model_press(d, c, acc);
    btn_next = 1'b1;
    repeat (8) @(negedge clk);
    btn_next = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; btn_next = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_phase = 0; m_a = 0; m_b = 0; m_cin = 0; m_led = 0; m_cc = 0;
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; data_sw = 4'h0; cin_sw = 1'b0; btn_next = 1'b0; acc_mode = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();
    check_all("reset");

    // Basic addition 5 + 3
    do_press(4'h5, 1'b0, 1'b0);
    check_all("load_a");
    do_press(4'h3, 1'b0, 1'b0);
    check_all("add_5_3");
    chk("led_5_3", int'(led), 5'b01000);

    // Accumulate: 8 fed back as A, then + 7
    do_press(4'h0, 1'b0, 1'b1);
    check_all("acc_show_press");
    chk("acc_a_is_8", int'({adder_in[7], adder_in[5], adder_in[3], adder_in[0]}), 8);
    do_press(4'h7, 1'b0, 1'b0);
    check_all("acc_add");
    chk("led_8_7", int'(led), 5'b01111);

    // 9 + 8 + 1 with carry-out
    do_press(4'h0, 1'b0, 1'b0);
    do_press(4'h9, 1'b0, 1'b0);
    do_press(4'h8, 1'b1, 1'b0);
    check_all("add_9_8_1");
    chk("led_9_8_1", int'(led), 5'b10010);

    // Bounce: only one debounced press should come through
    do_reset();
    state_changes = 0;
    data_sw = 4'hA;
    for (int i = 0; i < 20; i++) begin
      btn_next = ((i / 2) % 2) == 0;
      @(negedge clk);
    end
    btn_next = 1'b1;
    repeat (6) @(negedge clk);
    btn_next = 1'b0;
    repeat (12) @(negedge clk);
    model_press(4'hA, 1'b0, 1'b0);
    chk("bounce_state_changes", state_changes, 1);
    check_all("bounce");

    // Reset in LOAD_B with A=F
    do_reset();
    do_press(4'hF, 1'b0, 1'b0);
    check_all("pre_midreset");
    do_reset();
    check_all("midreset");

    // Randomized sequences; switches wiggled afterwards must not reach adder_in
    for (int i = 0; i < 40; i++) begin
      do_press(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      data_sw = 4'($urandom_range(0, 15));
      cin_sw  = 1'($urandom_range(0, 1));
      repeat (3) @(negedge clk);
      check_all("random");
    end

    // Saturation of carry_count
    do_reset();
    for (int i = 0; i < 16; i++) begin
      do_press(4'hF, 1'b0, 1'b0);
      do_press(4'h1, 1'b0, 1'b0);
      chk("sat_led", int'(led), 5'b10000);
      chk("sat_count", int'(carry_count), (i + 1 > 15) ? 15 : i + 1);
      do_press(4'h0, 1'b0, 1'b0);
    end
    check_all("sat_end");

    repeat (4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
